// File: rtl/friscv_uart_pkg.sv
// Shared types and constants for the FRISCV UART transmit path.
package friscv_uart_pkg;

    localparam int   UART_DATAW     = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/friscv_uart_tx_if.sv
// Byte handshake between the APB UART register block (master) and the transmit serializer (slave).
interface friscv_uart_tx_if;
    import friscv_uart_pkg::*;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [UART_DATAW-1:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/friscv_uart_baudgen.sv
// Bit-period timer: down-counter reloaded from a divider captured on restart,
// pulsing o_tick on the last cycle of every bit period while running.
module friscv_uart_baudgen #(
    parameter int DIVW = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            srst,
    input  logic            i_restart,
    input  logic            i_run,
    input  logic [DIVW-1:0] i_div,
    output logic            o_tick
);

    logic [DIVW-1:0] r_div;
    logic [DIVW-1:0] r_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (srst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_restart) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_run) begin
            if (r_cnt == '0) r_cnt <= r_div;
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/friscv_uart_tx.sv
// UART transmit serializer: start, 8 data bits LSB-first, optional parity, 1/2 stop bits.
// Optional parity bit enabled by defining FRISCV_UART_PARITY_EN (adds parity_odd input).
module friscv_uart_tx
    import friscv_uart_pkg::*;
#(
    parameter int DIVW  = 16,
    parameter int DATAW = 8
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            srst,
    input  logic            en,
    input  logic [DIVW-1:0] baud_div,
    input  logic            stop2,
`ifdef FRISCV_UART_PARITY_EN
    input  logic            parity_odd,
`endif
    friscv_uart_tx_if.slave s_if,
    output logic            busy,
    output logic            uart_tx
);

    localparam int             BITW     = $clog2(DATAW);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DATAW - 1);

    uart_state_t     r_state;
    logic            r_tx;
    logic            r_ready;
    logic [BITW-1:0] r_bit;
    logic            r_stop_half;
    logic            r_stop2;
    logic [DATAW-1:0] r_data;
`ifdef FRISCV_UART_PARITY_EN
    logic            r_par;
`endif

    uart_state_t     w_nxt_state;
    logic            w_nxt_tx;
    logic            w_nxt_ready;
    logic [BITW-1:0] w_nxt_bit;
    logic            w_nxt_stop_half;
    logic            w_nxt_stop2;
    logic            w_restart;
    logic            w_tick;
    logic            w_hs;
    logic [BITW-1:0] w_bit_inc;

    assign w_hs      = s_if.tx_valid && r_ready;
    assign w_bit_inc = r_bit + 1'b1;

    friscv_uart_baudgen #(
        .DIVW (DIVW)
    ) u_baudgen (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .i_restart (w_restart),
        .i_run     (r_state != IDLE),
        .i_div     (baud_div),
        .o_tick    (w_tick)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_tx        <= UART_LINE_IDLE;
            r_ready     <= 1'b0;
            r_bit       <= '0;
            r_stop_half <= 1'b0;
            r_stop2     <= 1'b0;
        end else if (srst) begin
            r_state     <= IDLE;
            r_tx        <= UART_LINE_IDLE;
            r_ready     <= 1'b0;
            r_bit       <= '0;
            r_stop_half <= 1'b0;
            r_stop2     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_tx        <= w_nxt_tx;
            r_ready     <= w_nxt_ready;
            r_bit       <= w_nxt_bit;
            r_stop_half <= w_nxt_stop_half;
            r_stop2     <= w_nxt_stop2;
        end
    end

    // Payload is captured only at the handshake and needs no reset.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            r_data <= s_if.tx_data;
`ifdef FRISCV_UART_PARITY_EN
            r_par  <= (^s_if.tx_data) ^ parity_odd;
`endif
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_tx        = r_tx;
        w_nxt_ready     = r_ready;
        w_nxt_bit       = r_bit;
        w_nxt_stop_half = r_stop_half;
        w_nxt_stop2     = r_stop2;
        w_restart       = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_tx    = UART_LINE_IDLE;
                w_nxt_ready = en;
                if (w_hs) begin
                    w_nxt_state = START;
                    w_nxt_tx    = ~UART_LINE_IDLE;
                    w_nxt_ready = 1'b0;
                    w_nxt_stop2 = stop2;
                    w_restart   = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_nxt_state = DATA;
                    w_nxt_tx    = r_data[0];
                    w_nxt_bit   = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit == BIT_LAST) begin
`ifdef FRISCV_UART_PARITY_EN
                        w_nxt_state = PARITY;
                        w_nxt_tx    = r_par;
`else
                        w_nxt_state = STOP;
                        w_nxt_tx    = UART_LINE_IDLE;
`endif
                        w_nxt_stop_half = 1'b0;
                    end else begin
                        w_nxt_bit = w_bit_inc;
                        w_nxt_tx  = r_data[w_bit_inc];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_nxt_state     = STOP;
                    w_nxt_tx        = UART_LINE_IDLE;
                    w_nxt_stop_half = 1'b0;
                end
            end
            STOP: begin
                w_nxt_tx = UART_LINE_IDLE;
                // With two stop bits the first tick only marks the half-way point.
                if (w_tick) begin
                    if (r_stop2 && !r_stop_half) begin
                        w_nxt_stop_half = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_ready = en;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_tx    = UART_LINE_IDLE;
            end
        endcase
    end

    assign s_if.tx_ready = r_ready;
    assign busy          = (r_state != IDLE);
    assign uart_tx       = r_tx;

endmodule

// File: doc/friscv_uart_tx.md
Name: friscv_uart_tx

Overview:
- Transmit serializer sitting directly downstream of the APB UART register block.
- Accepts one byte at a time over a valid/ready handshake and emits a standard asynchronous serial frame on uart_tx.
- Frame: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Bit timing comes from a programmable clock divider.

Parameters:
- DIVW, 16, width of the baud divider input
- DATAW, 8, data bits per frame; only 8 is supported

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset, asynchronous, active-low
- srst  input  1  synchronous reset, active-high; same effect as aresetn
- en  input  1  transmitter enable
- baud_div  input  DIVW  bit period in aclk cycles, minus 1
- stop2  input  1  1 = two stop bits, 0 = one stop bit
- tx_valid  input  1  byte available from the register block
- tx_ready  output  1  serializer can accept a byte
- tx_data  input  8  byte to send
- busy  output  1  frame in progress
- uart_tx  output  1  serial line; idle high

Behaviour:
- Reset (aresetn low or srst high):
  - uart_tx=1, tx_ready=0, busy=0, state=IDLE, counters cleared.
  - Asynchronous reset mid-frame drives uart_tx high immediately and abandons the frame.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx_ready = en (registered); uart_tx=1.
  - Handshake occurs when tx_valid && tx_ready.
  - On handshake: latch tx_data, baud_div and stop2; go to START; tx_ready falls next cycle.
- START:
  - uart_tx=0, asserted in the cycle after the handshake (1-cycle latency).
  - Lasts baud_div+1 cycles.
- DATA:
  - 8 bits, LSB first; each bit lasts baud_div+1 cycles.
  - 3-bit index counts 0..7; leave DATA after index 7 expires.
- STOP:
  - uart_tx=1 for (baud_div+1) cycles, doubled when latched stop2=1.
- Return to IDLE: at least one IDLE cycle (line high) before the next start bit.
  - With tx_valid held high, frame N+1 start bit begins exactly 2 cycles after frame N stop period ends.
- Frame length: (1+8+stopbits)*(baud_div+1) cycles, plus parity bit if enabled.
- busy = 1 in every state except IDLE.
- baud_div=0: bit period is 1 cycle; legal.
- baud_div changes mid-frame have no effect until the next handshake.
- en deasserted mid-frame: current frame completes; no new handshake while en=0.
- tx_data is ignored when no handshake occurs.
- uart_tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: FRISCV_UART_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit, latched at handshake).
  - PARITY state follows DATA and lasts one bit period.
  - Parity bit = XOR of the 8 data bits, inverted when parity_odd=1.
- Undefined: no parity_odd port; DATA goes directly to STOP.

Decomposition:
- friscv_uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATAW=8 constant
  - line idle level constant
- Sub-module friscv_uart_baudgen:
  - DIVW-bit down-counter, reloaded with the latched divider on restart.
  - Outputs a single-cycle bit_tick at the end of each bit period.
  - Restart pulse issued by the FSM on handshake.

Test Plan:
- Reset then idle: en=1, no valid -> uart_tx=1, busy=0, tx_ready=1 from the 2nd cycle after reset release.
- baud_div=3, stop2=0, send 0xA5:
  - uart_tx goes low 1 cycle after handshake.
  - Bits 1,0,1,0,0,1,0,1 follow, 4 cycles each; stop high 4 cycles.
  - busy high for 40 cycles.
- Back-to-back 0x00 then 0xFF with tx_valid held, baud_div=0:
  - Exactly 1 idle-high cycle between frames.
  - Second byte accepted only after busy drops.
- stop2=1, baud_div=1, send 0x55 -> stop period high for 4 cycles; total frame 22 cycles.
- Assert aresetn low at DATA bit 4 -> uart_tx high same cycle.
  - After release, a new byte 0x3C is transmitted correctly from its start bit.
- With FRISCV_UART_PARITY_EN, send 0x07, baud_div=2:
  - parity_odd=0 -> parity bit 1.
  - parity_odd=1 -> parity bit 0.
  - Frame is 33 cycles.
